// File: rtl/frame_buf_if.sv
// Camera-write / display-read / BRAM-port bundle for the ping-pong frame buffer controller.
// master = pixel source and display timing side, slave = frame_buf_ctrl.
interface frame_buf_if #(
  parameter int ADDR_W = 17
);
  logic              wr_vsync;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              rd_vsync;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   bram_addra;
  logic [11:0]       bram_dina;
  logic              bram_wea;
  logic [ADDR_W:0]   bram_addrb;
  logic              frame_ready;
  logic [15:0]       frame_cnt;
  logic [15:0]       drop_cnt;
  logic              short_err;

  modport master (
    output wr_vsync, wr_en, wr_addr, wr_data, rd_vsync, rd_addr,
    input  bram_addra, bram_dina, bram_wea, bram_addrb,
    input  frame_ready, frame_cnt, drop_cnt, short_err
  );

  modport slave (
    input  wr_vsync, wr_en, wr_addr, wr_data, rd_vsync, rd_addr,
    output bram_addra, bram_dina, bram_wea, bram_addrb,
    output frame_ready, frame_cnt, drop_cnt, short_err
  );
endinterface

// File: rtl/frame_buf_ctrl.sv
// Double-buffered camera frame store: writer fills one BRAM bank while display reads the other, swapping on display vsync.
// Port-A write is one cycle after wr_en; no backpressure -- frames arriving while a finished frame awaits a swap are dropped.
module frame_buf_ctrl #(
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = 76800
) (
  input  logic       clk,
  input  logic       rst,
  frame_buf_if.slave bus
);
  localparam int               CNT_W    = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD, DROP} wr_state_t;

  wr_state_t        state;
  logic             wr_vs_q;
  logic             rd_vs_q;
  logic             wr_edge;
  logic             rd_edge;
  logic             wr_bank;
  logic             rd_bank;
  logic [CNT_W-1:0] pix_cnt;
  logic             swap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_vs_q <= 1'b0;
      rd_vs_q <= 1'b0;
      wr_edge <= 1'b0;
      rd_edge <= 1'b0;
    end else begin
      wr_vs_q <= bus.wr_vsync;
      rd_vs_q <= bus.rd_vsync;
      wr_edge <= bus.wr_vsync & ~wr_vs_q;
      rd_edge <= bus.rd_vsync & ~rd_vs_q;
    end
  end

  // frame_ready is only ever 1 in HOLD/DROP, so a swap never disturbs an in-progress frame
  assign swap           = rd_edge & bus.frame_ready;
  assign bus.bram_addrb = {rd_bank, bus.rd_addr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b1;
      pix_cnt         <= '0;
      bus.frame_ready <= 1'b0;
      bus.bram_wea    <= 1'b0;
      bus.bram_addra  <= '0;
      bus.bram_dina   <= '0;
      bus.frame_cnt   <= '0;
      bus.drop_cnt    <= '0;
      bus.short_err   <= 1'b0;
    end else begin
      bus.bram_wea <= 1'b0;
      if (swap) begin
        rd_bank         <= wr_bank;
        wr_bank         <= rd_bank;
        bus.frame_ready <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (wr_edge) begin
            state   <= WRITE;
            pix_cnt <= '0;
          end
        end
        WRITE: begin
          // a new vsync wins over a coincident pixel: the partial frame is abandoned in place
          if (wr_edge) begin
            bus.short_err <= 1'b1;
            pix_cnt       <= '0;
          end else if (bus.wr_en) begin
            bus.bram_wea   <= 1'b1;
            bus.bram_addra <= {wr_bank, bus.wr_addr};
            bus.bram_dina  <= bus.wr_data;
            pix_cnt        <= pix_cnt + 1'b1;
            if (pix_cnt == LAST_PIX) begin
              bus.frame_ready <= 1'b1;
              bus.frame_cnt   <= bus.frame_cnt + 16'd1;
              state           <= HOLD;
            end
          end
        end
        HOLD, DROP: begin
          if (swap) begin
            state   <= wr_edge ? WRITE : IDLE;
            pix_cnt <= '0;
          end else if (wr_edge) begin
            bus.drop_cnt <= bus.drop_cnt + 16'd1;
            state        <= DROP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed scenarios plus random traffic against a frame-level model of the ping-pong buffer.
module tb_frame_buf_ctrl;
  localparam int AW = 8;
  localparam int FP = 16;

  logic clk;
  logic rst;
  frame_buf_if #(.ADDR_W(AW)) bus ();

  frame_buf_ctrl #(.ADDR_W(AW), .FRAME_PIXELS(FP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int n_wea;
  logic last_wr_msb;

  // model: which bank the camera owns, whether a finished frame awaits display
  logic          m_wbank, m_rbank, m_ready, m_cap, m_short;
  int            m_cnt;
  logic [15:0]   m_frames, m_drops;
  logic          m_wea;
  logic [AW:0]   m_addra;
  logic [11:0]   m_dina;
  logic          m_prev_wv, m_prev_rv, m_pw, m_pr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wbank = 1'b0; m_rbank = 1'b1; m_ready = 1'b0; m_cap = 1'b0; m_short = 1'b0;
    m_cnt = 0; m_frames = '0; m_drops = '0;
    m_wea = 1'b0; m_addra = '0; m_dina = '0;
    m_prev_wv = 1'b0; m_prev_rv = 1'b0; m_pw = 1'b0; m_pr = 1'b0;
  endtask

  // advance the model by one clock using the inputs just driven
  task automatic model_step(input logic en, input logic wv, input logic rv);
    logic w, r, t;
    w = m_pw;
    r = m_pr;
    m_pw = wv & ~m_prev_wv;
    m_pr = rv & ~m_prev_rv;
    m_prev_wv = wv;
    m_prev_rv = rv;
    m_wea = 1'b0;
    if (m_ready) begin
      if (r) begin
        t = m_wbank; m_wbank = m_rbank; m_rbank = t;
        m_ready = 1'b0;
        m_cap = w;
        m_cnt = 0;
      end else if (w) begin
        m_drops = m_drops + 16'd1;
      end
    end else if (m_cap) begin
      if (w) begin
        m_short = 1'b1;
        m_cnt = 0;
      end else if (en) begin
        m_wea = 1'b1;
        m_addra = {m_wbank, bus.wr_addr};
        m_dina = bus.wr_data;
        m_cnt++;
        if (m_cnt == FP) begin
          m_ready = 1'b1;
          m_frames = m_frames + 16'd1;
          m_cap = 1'b0;
        end
      end
    end else if (w) begin
      m_cap = 1'b1;
      m_cnt = 0;
    end
  endtask

  task automatic compare_all();
    chk("wea", bus.bram_wea, m_wea);
    if (m_wea) begin
      chk("addra", bus.bram_addra, m_addra);
      chk("dina", bus.bram_dina, m_dina);
    end
    chk("ready", bus.frame_ready, m_ready);
    chk("frame_cnt", bus.frame_cnt, m_frames);
    chk("drop_cnt", bus.drop_cnt, m_drops);
    chk("short_err", bus.short_err, m_short);
    chk("addrb", bus.bram_addrb, {m_rbank, bus.rd_addr});
    if (bus.bram_wea) begin
      n_wea++;
      last_wr_msb = bus.bram_addra[AW];
    end
  endtask

  task automatic step(input logic en, input logic wv, input logic rv);
    @(negedge clk);
    compare_all();
    bus.wr_en    = en;
    bus.wr_vsync = wv;
    bus.rd_vsync = rv;
    bus.wr_addr  = AW'($urandom);
    bus.wr_data  = 12'($urandom);
    bus.rd_addr  = AW'($urandom);
    model_step(en, wv, rv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic writes(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_wea"}, bus.bram_wea, 0);
    chk({pfx, "_addra"}, bus.bram_addra, 0);
    chk({pfx, "_dina"}, bus.bram_dina, 0);
    chk({pfx, "_ready"}, bus.frame_ready, 0);
    chk({pfx, "_frames"}, bus.frame_cnt, 0);
    chk({pfx, "_drops"}, bus.drop_cnt, 0);
    chk({pfx, "_short"}, bus.short_err, 0);
    chk({pfx, "_addrb_msb"}, bus.bram_addrb[AW], 1);
  endtask

  initial begin
    int wea_mark;
    n_chk = 0; n_fail = 0; n_wea = 0; last_wr_msb = 1'b0;
    rst = 1'b1;
    bus.wr_vsync = 1'b0; bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_vsync = 1'b0; bus.rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;

    // writes before any vsync are ignored; then a basic frame into bank 0
    writes(4);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    writes(FP);
    idle(2);
    chk("basic_ready", bus.frame_ready, 1);
    chk("basic_frames", bus.frame_cnt, 1);
    chk("basic_msb", last_wr_msb, 0);

    // display swap hands bank 0 to the reader
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    chk("swap_addrb_msb", bus.bram_addrb[AW], 0);
    chk("swap_ready", bus.frame_ready, 0);

    // second frame lands in bank 1
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < FP; i++) step(1'b1, 1'b0, 1'b0);
    idle(2);
    chk("frame2_msb", last_wr_msb, 1);
    chk("frame2_frames", bus.frame_cnt, 2);

    // third frame with no display swap is dropped
    wea_mark = n_wea;
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    writes(FP);
    idle(2);
    chk("drop_no_writes", n_wea - wea_mark, 0);
    chk("drop_cnt_one", bus.drop_cnt, 1);
    chk("drop_frames", bus.frame_cnt, 2);

    // coincident camera and display vsync: swap, no drop, write into freed bank 0
    step(1'b0, 1'b1, 1'b1);
    idle(2);
    writes(10);
    idle(1);
    chk("coinc_drops", bus.drop_cnt, 1);
    chk("coinc_msb", last_wr_msb, 0);

    // short frame: abandon after 10 pixels, restart in bank 0
    step(1'b0, 1'b1, 1'b0);
    idle(2);
    chk("short_err_set", bus.short_err, 1);
    chk("short_frames", bus.frame_cnt, 2);
    writes(FP);
    idle(2);
    chk("short_restart_msb", last_wr_msb, 0);
    chk("short_restart_frames", bus.frame_cnt, 3);

    // mid-frame reset after 8 writes
    step(1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    writes(8);
    @(negedge clk);
    compare_all();
    #2 rst = 1'b1;
    model_reset();
    #1 check_reset_values("mrst");
    bus.wr_en = 1'b1;
    bus.wr_vsync = 1'b0;
    bus.rd_vsync = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wea_mark = n_wea;
    writes(6);
    idle(1);
    chk("mrst_no_writes", n_wea - wea_mark, 0);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    writes(FP);
    idle(2);
    chk("mrst_frames", bus.frame_cnt, 1);
    chk("mrst_msb", last_wr_msb, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0), ($urandom_range(0, 24) == 0));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_buf_ctrl.md
FRAME_BUF_CTRL -- requirements
Module: frame_buf_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, per-bank pixel address width.
REQ-002 SHALL have parameter FRAME_PIXELS, default 76800, pixel writes per complete frame.
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_vsync  input  1  camera-side frame sync; a rising edge starts a frame.
REQ-006 SHALL have port wr_en  input  1  pixel write strobe from format converter.
REQ-007 SHALL have port wr_addr  input  ADDR_W  pixel address within frame.
REQ-008 SHALL have port wr_data  input  12  RGB444 pixel.
REQ-009 SHALL have port rd_vsync  input  1  display-side frame sync; a rising edge marks a display frame start.
REQ-010 SHALL have port rd_addr  input  ADDR_W  display read address.
REQ-011 SHALL have port bram_addra  output  ADDR_W+1  BRAM port-A address {wr_bank, addr}.
REQ-012 SHALL have port bram_dina  output  12  BRAM port-A data.
REQ-013 SHALL have port bram_wea  output  1  BRAM port-A write enable.
REQ-014 SHALL have port bram_addrb  output  ADDR_W+1  BRAM port-B address {rd_bank, rd_addr}.
REQ-015 SHALL have port frame_ready  output  1  completed frame pending a swap.
REQ-016 SHALL have port frame_cnt  output  16  frames completed.
REQ-017 SHALL have port drop_cnt  output  16  camera frames discarded.
REQ-018 SHALL have port short_err  output  1  sticky flag: frame aborted before FRAME_PIXELS writes.

Function
REQ-019 SHALL detect rising edges of wr_vsync and rd_vsync with one-cycle registered edge detectors (edge pulse asserted the cycle after the input is first sampled high).
REQ-020 SHALL run a writer state machine with states IDLE, WRITE, HOLD, DROP.
REQ-021 SHALL in IDLE ignore wr_en and enter WRITE on a wr_vsync edge, clearing the pixel counter.
REQ-022 SHALL in WRITE register wr_en/wr_addr/wr_data to bram_wea/bram_addra/bram_dina with exactly one cycle of latency, using the current wr_bank as the MSB, and count accepted writes.
REQ-023 SHALL when the write taking the count to FRAME_PIXELS is accepted, set frame_ready, increment frame_cnt, and enter HOLD on the next cycle.
REQ-024 SHALL on a wr_vsync edge in WRITE before the count reaches FRAME_PIXELS, set short_err, clear the counter, and restart WRITE in the same bank.
REQ-025 SHALL in HOLD and DROP force bram_wea low; on a wr_vsync edge while frame_ready is still 1, increment drop_cnt and enter or stay in DROP.
REQ-026 SHALL on a rd_vsync edge with frame_ready already 1 (registered value), swap banks: rd_bank <= wr_bank, wr_bank <= old rd_bank, clear frame_ready, and move the writer from HOLD or DROP to IDLE.
REQ-027 SHALL when the swap edge and a wr_vsync edge coincide, drop_cnt is unchanged and the writer enters WRITE directly into the newly freed bank.
REQ-028 SHALL when frame completion and a rd_vsync edge coincide, perform no swap; the swap occurs at the next rd_vsync edge.
REQ-029 SHALL drive bram_addrb combinationally as {rd_bank, rd_addr}; rd_bank changes only on a swap.
REQ-030 SHALL let frame_cnt and drop_cnt wrap modulo 2^16 without saturation.
REQ-031 SHALL never let wr_bank equal rd_bank.

Reset
REQ-032 SHALL on rst asynchronously set writer state IDLE, wr_bank 0, rd_bank 1, frame_ready 0, bram_wea 0, bram_addra 0, bram_dina 0, frame_cnt 0, drop_cnt 0, short_err 0, pixel counter 0, and edge-detector history 0.
REQ-033 SHALL when rst is asserted mid-frame, make no further writes after the assertion, and after deassertion remain in IDLE until a new wr_vsync edge.

Verification
REQ-034 SHALL cover the basic frame: FRAME_PIXELS=16, wr_vsync pulse then 16 wr_en writes -> bram_addra MSB 0, bram_wea one cycle delayed, frame_ready=1, frame_cnt=1.
REQ-035 SHALL cover the swap: after REQ-034 a rd_vsync pulse -> rd_bank 0, bram_addrb MSB 0, frame_ready 0; the next frame writes with MSB 1.
REQ-036 SHALL cover frame drop: two complete frames with no rd_vsync -> second frame produces bram_wea=0 throughout and drop_cnt=1.
REQ-037 SHALL cover the short frame: 10 writes then wr_vsync -> short_err=1, frame_cnt unchanged, restart in bank 0.
REQ-038 SHALL cover coincident edges: wr_vsync and rd_vsync edges in the same cycle with frame_ready=1 -> swap, drop_cnt unchanged, writes go to the freed bank.
REQ-039 SHALL cover mid-frame reset: rst asserted after 8 writes -> all outputs at reset values immediately, and no writes occur until a new wr_vsync edge.
